// File: rtl/mbus_timer.sv
`default_nettype none
// ============================================================================
// Module   : mbus_timer
// Purpose  : mbus slave with an 8-slot register window holding a prescaled
//            auto-reload down-counter timer with overflow flag and irq.
//            Define MBUS_TIMER_CAPTURE_EN to enable the cap_in capture unit.
// Revision : 1.0  initial release
// ============================================================================
module mbus_timer #(
    parameter int                   WIDTH     = 32,
    parameter int                   ADDR_SIZE = 32,
    parameter logic [ADDR_SIZE-1:0] BASE      = 'hff20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_SIZE-1:0] mbus_ain,
    input  logic [WIDTH-1:0]     mbus_din,
    input  logic                 mbus_wen,
    output logic [WIDTH-1:0]     mbus_dout,
    output logic                 mbus_sel,
    input  logic                 cap_in,
    output logic                 irq
);
    localparam logic [2:0] c_IDX_CTRL   = 3'd0;
    localparam logic [2:0] c_IDX_RELOAD = 3'd1;
    localparam logic [2:0] c_IDX_COUNT  = 3'd2;
    localparam logic [2:0] c_IDX_STAT   = 3'd3;
    localparam logic [2:0] c_IDX_CAP    = 3'd4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             en_q, en_d, auto_q, auto_d, ie_q, ie_d;
    logic [7:0]       pre_q, pre_d, presc_q, presc_d;
    logic [WIDTH-1:0] reload_q, reload_d, count_q, count_d, cap_q, cap_d;
    logic             ovf_q, ovf_d, capf_q, capf_d;

    logic       w_hit;
    logic [2:0] w_idx;
    logic       w_wr_ctrl, w_wr_reload, w_wr_count, w_wr_stat;
    logic       w_tick, w_expire, w_cap_edge;

    assign w_hit       = (mbus_ain[ADDR_SIZE-1:3] == BASE[ADDR_SIZE-1:3]);
    assign w_idx       = mbus_ain[2:0];
    assign w_wr_ctrl   = w_hit && mbus_wen && (w_idx == c_IDX_CTRL);
    assign w_wr_reload = w_hit && mbus_wen && (w_idx == c_IDX_RELOAD);
    assign w_wr_count  = w_hit && mbus_wen && (w_idx == c_IDX_COUNT);
    assign w_wr_stat   = w_hit && mbus_wen && (w_idx == c_IDX_STAT);

    assign w_tick   = (state_q == ST_RUN) && (presc_q == pre_q);
    // A CPU write to COUNT pre-empts both the decrement and the expiry.
    assign w_expire = w_tick && (count_q == '0) && !w_wr_count;

`ifdef MBUS_TIMER_CAPTURE_EN
    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= cap_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign w_cap_edge = sync2_q & ~prev_q;
`else
    logic unused_cap_in;
    assign unused_cap_in = cap_in;
    assign w_cap_edge    = 1'b0;
`endif

    always_comb begin
        en_d     = en_q;
        auto_d   = auto_q;
        ie_d     = ie_q;
        pre_d    = pre_q;
        reload_d = reload_q;
        count_d  = count_q;
        presc_d  = presc_q;

        if (w_wr_ctrl) begin
            en_d   = mbus_din[0];
            auto_d = mbus_din[1];
            ie_d   = mbus_din[2];
            pre_d  = mbus_din[15:8];
        end else if (w_expire && !auto_q) begin
            en_d = 1'b0;
        end

        if (w_wr_reload) begin
            reload_d = mbus_din;
        end

        // Reload only when the timer keeps running after expiry.
        if (w_wr_count) begin
            count_d = mbus_din;
        end else if (w_tick) begin
            if (count_q != '0) begin
                count_d = count_q - WIDTH'(1);
            end else if (auto_q && en_d) begin
                count_d = reload_q;
            end
        end

        if (w_wr_ctrl) begin
            presc_d = 8'd0;
        end else if (state_q == ST_RUN) begin
            presc_d = w_tick ? 8'd0 : presc_q + 8'd1;
        end

        ovf_d   = (ovf_q & ~(w_wr_stat & mbus_din[0])) | w_expire;
        capf_d  = (capf_q & ~(w_wr_stat & mbus_din[2])) | w_cap_edge;
        cap_d   = w_cap_edge ? count_q : cap_q;
        state_d = en_d ? ST_RUN : ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            en_q     <= 1'b0;
            auto_q   <= 1'b0;
            ie_q     <= 1'b0;
            pre_q    <= 8'd0;
            presc_q  <= 8'd0;
            reload_q <= '0;
            count_q  <= '0;
            cap_q    <= '0;
            ovf_q    <= 1'b0;
            capf_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            auto_q   <= auto_d;
            ie_q     <= ie_d;
            pre_q    <= pre_d;
            presc_q  <= presc_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            cap_q    <= cap_d;
            ovf_q    <= ovf_d;
            capf_q   <= capf_d;
        end
    end

    always_comb begin
        mbus_dout = '0;
        if (w_hit) begin
            case (w_idx)
                c_IDX_CTRL: begin
                    mbus_dout[0]    = en_q;
                    mbus_dout[1]    = auto_q;
                    mbus_dout[2]    = ie_q;
                    mbus_dout[15:8] = pre_q;
                end
                c_IDX_RELOAD: mbus_dout = reload_q;
                c_IDX_COUNT:  mbus_dout = count_q;
                c_IDX_STAT: begin
                    mbus_dout[0] = ovf_q;
                    mbus_dout[1] = (state_q == ST_RUN);
                    mbus_dout[2] = capf_q;
                end
                c_IDX_CAP:    mbus_dout = cap_q;
                default:      mbus_dout = '0;
            endcase
        end
    end

    assign mbus_sel = w_hit;
    assign irq      = ovf_q & ie_q;

endmodule
`default_nettype wire

// File: tb/tb_mbus_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mbus_timer
// Purpose  : Self-checking bench for mbus_timer: directed scenarios plus
//            randomized bus traffic against a behavioural register model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mbus_timer;
    localparam logic [31:0] BASE = 32'hff20;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mbus_ain, mbus_din, mbus_dout;
    logic        mbus_wen, mbus_sel, cap_in, irq;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    bit          m_en, m_auto, m_ie, m_ovf, m_capf;
    logic [7:0]  m_pre;
    int          m_presc;
    logic [31:0] m_reload, m_count, m_cap;
    bit          m_s1, m_s2, m_prev;

    mbus_timer #(.WIDTH(32), .ADDR_SIZE(32), .BASE(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .mbus_ain  (mbus_ain),
        .mbus_din  (mbus_din),
        .mbus_wen  (mbus_wen),
        .mbus_dout (mbus_dout),
        .mbus_sel  (mbus_sel),
        .cap_in    (cap_in),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[31:3] != BASE[31:3]) return 32'd0;
        case (a[2:0])
            3'd0:    return {16'd0, m_pre, 5'd0, m_ie, m_auto, m_en};
            3'd1:    return m_reload;
            3'd2:    return m_count;
            3'd3:    return {29'd0, m_capf, m_en, m_ovf};
            3'd4:    return m_cap;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_en = 0; m_auto = 0; m_ie = 0; m_ovf = 0; m_capf = 0;
        m_pre = 8'd0; m_presc = 0; m_reload = 0; m_count = 0; m_cap = 0;
        m_s1 = 0; m_s2 = 0; m_prev = 0;
    endtask

    // One clock of the register-level behaviour, using pre-edge values.
    task automatic model_step(input logic wen, input logic [31:0] a, input logic [31:0] d, input logic ci);
        bit wr, tick, expire, keep_running;
        int slot;
        wr     = wen && (a[31:3] == BASE[31:3]);
        slot   = int'(a[2:0]);
        tick   = m_en && (m_presc == int'(m_pre));
        expire = tick && (m_count == 0) && !(wr && slot == 2);
        keep_running = m_auto && !(wr && slot == 0 && !d[0]);
`ifdef MBUS_TIMER_CAPTURE_EN
        if (m_s2 && !m_prev) begin
            m_cap  = m_count;
            m_capf = 1;
        end else if (wr && slot == 3 && d[2]) begin
            m_capf = 0;
        end
        m_prev = m_s2; m_s2 = m_s1; m_s1 = ci;
`endif
        if (wr && slot == 2)            m_count = d;
        else if (tick && m_count != 0)  m_count = m_count - 1;
        else if (expire)                m_count = keep_running ? m_reload : 32'd0;
        if (wr && slot == 1) m_reload = d;
        if (wr && slot == 3 && d[0]) m_ovf = 0;
        if (expire) m_ovf = 1;
        if (wr && slot == 0)  m_presc = 0;
        else if (m_en)        m_presc = tick ? 0 : m_presc + 1;
        if (expire && !m_auto) m_en = 0;
        if (wr && slot == 0) begin
            m_en = d[0]; m_auto = d[1]; m_ie = d[2]; m_pre = d[15:8];
        end
    endtask

    // Apply bus inputs in the low phase and compare outputs with the model.
    task automatic drive(input logic wen, input logic [31:0] a, input logic [31:0] d);
        mbus_wen = wen; mbus_ain = a; mbus_din = d;
        #1;
        check_eq("sel",  {31'd0, mbus_sel}, {31'd0, a[31:3] == BASE[31:3]});
        check_eq("dout", mbus_dout, m_read(a));
        check_eq("irq",  {31'd0, irq}, {31'd0, m_ovf & m_ie});
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else model_step(mbus_wen, mbus_ain, mbus_din, cap_in);
        @(negedge clk);
    endtask

    task automatic wr(input int slot, input logic [31:0] d);
        drive(1'b1, BASE + 32'(slot), d);
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, BASE, 32'd0);
        step();
        reset = 1'b0;
    endtask

    initial begin
        int exp_cnt [5];
        logic [31:0] a, d;
        int sel;

        reset = 1'b1; mbus_wen = 0; mbus_ain = 0; mbus_din = 0; cap_in = 0;
        model_reset();
        @(negedge clk);
        step();
        step();
        reset = 1'b0;

        // Reset state: window reads zero, outside the window deselected
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, BASE + 32'(i), 32'd0);
            check_eq("rst_slot", mbus_dout, 32'd0);
            step();
        end
        drive(1'b0, BASE + 32'd8, 32'd0);
        check_eq("out_sel", {31'd0, mbus_sel}, 32'd0);
        check_eq("out_dout", mbus_dout, 32'd0);
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        step();

        // Auto-reload, PRE=0
        exp_cnt[0] = 3; exp_cnt[1] = 2; exp_cnt[2] = 1; exp_cnt[3] = 0; exp_cnt[4] = 3;
        wr(1, 32'd3);
        wr(2, 32'd3);
        wr(0, 32'h3);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, BASE + 32'd2, 32'd0);
            check_eq("auto_cnt", mbus_dout, 32'(exp_cnt[i]));
            if (i == 3) begin
                drive(1'b0, BASE + 32'd3, 32'd0);
                check_eq("auto_stat0", mbus_dout, 32'd2);
            end
            step();
        end
        drive(1'b0, BASE + 32'd3, 32'd0);
        check_eq("auto_stat1", mbus_dout, 32'd3);
        step();

        // One-shot with prescaler 4
        do_reset();
        wr(2, 32'd2);
        wr(0, 32'h405);
        for (int i = 0; i < 14; i++) begin
            drive(1'b0, BASE + 32'd2, 32'd0);
            step();
        end
        drive(1'b0, BASE + 32'd3, 32'd0);
        check_eq("os_stat_pre", mbus_dout, 32'd2);
        check_eq("os_irq_pre", {31'd0, irq}, 32'd0);
        step();
        drive(1'b0, BASE + 32'd3, 32'd0);
        check_eq("os_stat", mbus_dout, 32'd1);
        check_eq("os_irq", {31'd0, irq}, 32'd1);
        drive(1'b0, BASE, 32'd0);
        check_eq("os_ctrl", mbus_dout, 32'h404);
        drive(1'b0, BASE + 32'd2, 32'd0);
        check_eq("os_cnt", mbus_dout, 32'd0);
        step();
        wr(3, 32'd1);
        drive(1'b0, BASE + 32'd3, 32'd0);
        check_eq("os_clr_irq", {31'd0, irq}, 32'd0);
        step();

        // Write vs tick, W1C vs expiry
        do_reset();
        wr(2, 32'd5);
        wr(0, 32'h1);
        wr(2, 32'd9);
        drive(1'b0, BASE + 32'd2, 32'd0);
        check_eq("wr_beats_tick", mbus_dout, 32'd9);
        step();
        wr(2, 32'd0);
        wr(3, 32'd1);
        drive(1'b0, BASE + 32'd3, 32'd0);
        check_eq("set_beats_w1c", mbus_dout, 32'd1);
        drive(1'b0, BASE, 32'd0);
        check_eq("os_en_clr", mbus_dout, 32'd0);
        step();

        // Reset while running
        do_reset();
        wr(2, 32'd5);
        wr(0, 32'h5);
        reset = 1'b1;
        drive(1'b0, BASE + 32'd2, 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, BASE + 32'(i), 32'd0);
            check_eq("midrst_slot", mbus_dout, 32'd0);
            step();
        end
        drive(1'b0, BASE + 32'd2, 32'd0);
        check_eq("midrst_stopped", mbus_dout, 32'd0);
        check_eq("midrst_irq", {31'd0, irq}, 32'd0);
        step();

        // Capture while idle (COUNT constant)
        do_reset();
        wr(2, 32'd77);
        cap_in = 1'b1;
        drive(1'b0, BASE + 32'd4, 32'd0);
        step();
        cap_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, BASE + 32'd4, 32'd0);
            step();
        end
        drive(1'b0, BASE + 32'd4, 32'd0);
`ifdef MBUS_TIMER_CAPTURE_EN
        check_eq("cap_val", mbus_dout, 32'd77);
        drive(1'b0, BASE + 32'd3, 32'd0);
        check_eq("cap_flag", mbus_dout, 32'd4);
`else
        check_eq("cap_val", mbus_dout, 32'd0);
        drive(1'b0, BASE + 32'd3, 32'd0);
        check_eq("cap_flag", mbus_dout, 32'd0);
`endif
        step();

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 11) == 0) cap_in = ~cap_in;
            sel = $urandom_range(0, 9);
            if (sel < 8)       a = BASE + 32'(sel);
            else if (sel == 8) a = BASE + 32'd8;
            else               a = $urandom;
            d = $urandom;
            if (sel == 0) d[15:8] = 8'($urandom_range(0, 3));
            if (sel == 1 || sel == 2) d = 32'($urandom_range(0, 12));
            drive($urandom_range(0, 3) == 0, a, d);
            step();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
